// File: rtl/packet_injector.sv
// packet_injector: transmit side of a router local port.
// Takes packet requests (destination x/y, length) from a core and emits HEAD/BODY/TAIL/HEADTAIL
// flits into the router LOCAL input port under credit flow control. Destinations outside the
// mesh are rejected with a one-cycle pkt_err_o pulse.
// MESH_SIZE_X and MESH_SIZE_Y must be at least 2. MAX_PKT_LEN must be at most 255.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   pkt_valid_i       packet request valid (accepted when pkt_ready_o is high)
//   pkt_ready_o       injector idle and able to accept a request
//   pkt_x_dest_i      request destination x
//   pkt_y_dest_i      request destination y
//   pkt_len_i         request length in flits (0 is treated as 1, values above MAX_PKT_LEN clamp)
//   pkt_err_o         one-cycle pulse: request rejected (destination out of mesh)
//   flit_valid_o      flit present this cycle (one credit consumed)
//   flit_type_o       0=HEAD 1=BODY 2=TAIL 3=HEADTAIL
//   flit_x_dest_o     packet destination x
//   flit_y_dest_o     packet destination y
//   flit_payload_o    {pkt_id, flit_idx}
//   credit_i          one-cycle pulse: one downstream buffer slot freed
//   credit_err_o      sticky: credit returned while the counter was already full
module packet_injector #(
  parameter int unsigned MESH_SIZE_X = 5,
  parameter int unsigned MESH_SIZE_Y = 7,
  parameter int unsigned BUFFER_SIZE = 8,
  parameter int unsigned MAX_PKT_LEN = 8,
  localparam int unsigned DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X),
  localparam int unsigned DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y),
  localparam int unsigned LEN_W = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pkt_valid_i,
  output logic                        pkt_ready_o,
  input  logic [DEST_ADDR_SIZE_X-1:0] pkt_x_dest_i,
  input  logic [DEST_ADDR_SIZE_Y-1:0] pkt_y_dest_i,
  input  logic [LEN_W-1:0]            pkt_len_i,
  output logic                        pkt_err_o,
  output logic                        flit_valid_o,
  output logic [1:0]                  flit_type_o,
  output logic [DEST_ADDR_SIZE_X-1:0] flit_x_dest_o,
  output logic [DEST_ADDR_SIZE_Y-1:0] flit_y_dest_o,
  output logic [15:0]                 flit_payload_o,
  input  logic                        credit_i,
  output logic                        credit_err_o
);

  localparam int unsigned CW = $clog2(BUFFER_SIZE + 1);

  localparam logic [1:0] FlitHead     = 2'd0;
  localparam logic [1:0] FlitBody     = 2'd1;
  localparam logic [1:0] FlitTail     = 2'd2;
  localparam logic [1:0] FlitHeadTail = 2'd3;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                      state_q, state_d;
  logic [CW-1:0]               credits_q, credits_d;
  logic [7:0]                  pkt_id_q, pkt_id_d;
  logic [7:0]                  idx_q, idx_d;
  logic [LEN_W-1:0]            len_q, len_d;
  logic [DEST_ADDR_SIZE_X-1:0] x_q, x_d;
  logic [DEST_ADDR_SIZE_Y-1:0] y_q, y_d;

  logic                        fv_q, fv_d;
  logic [1:0]                  ft_q, ft_d;
  logic [DEST_ADDR_SIZE_X-1:0] fx_q, fx_d;
  logic [DEST_ADDR_SIZE_Y-1:0] fy_q, fy_d;
  logic [15:0]                 fp_q, fp_d;
  logic                        pkt_err_q, pkt_err_d;
  logic                        credit_err_q, credit_err_d;

  logic             send;
  logic             dest_bad;
  logic             last;
  logic [LEN_W-1:0] len_eff;
  logic [7:0]       len_ext;

  // Zero-extend before comparing so power-of-two mesh sizes still compare correctly.
  assign dest_bad = (32'(pkt_x_dest_i) >= MESH_SIZE_X) || (32'(pkt_y_dest_i) >= MESH_SIZE_Y);
  assign len_ext  = 8'(len_q);
  assign last     = (idx_q + 8'd1) == len_ext;

  always_comb begin
    len_eff = pkt_len_i;
    if (pkt_len_i == '0) begin
      len_eff = LEN_W'(1);
    end else if (32'(pkt_len_i) > MAX_PKT_LEN) begin
      len_eff = LEN_W'(MAX_PKT_LEN);
    end
  end

  always_comb begin
    state_d      = state_q;
    credits_d    = credits_q;
    pkt_id_d     = pkt_id_q;
    idx_d        = idx_q;
    len_d        = len_q;
    x_d          = x_q;
    y_d          = y_q;
    fv_d         = 1'b0;
    ft_d         = FlitHead;
    fx_d         = '0;
    fy_d         = '0;
    fp_d         = '0;
    pkt_err_d    = 1'b0;
    credit_err_d = credit_err_q;
    send         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pkt_valid_i) begin
          if (dest_bad) begin
            pkt_err_d = 1'b1;
          end else begin
            x_d     = pkt_x_dest_i;
            y_d     = pkt_y_dest_i;
            len_d   = len_eff;
            idx_d   = 8'd0;
            state_d = StSend;
          end
        end
      end
      StSend: begin
        // Sending depends only on the registered count, so a credit returned at zero
        // unblocks transmission one cycle later.
        if (credits_q != '0) begin
          send  = 1'b1;
          fv_d  = 1'b1;
          fx_d  = x_q;
          fy_d  = y_q;
          fp_d  = {pkt_id_q, idx_q};
          if (len_q == LEN_W'(1)) begin
            ft_d = FlitHeadTail;
          end else if (idx_q == 8'd0) begin
            ft_d = FlitHead;
          end else if (last) begin
            ft_d = FlitTail;
          end else begin
            ft_d = FlitBody;
          end
          idx_d = idx_q + 8'd1;
          if (last) begin
            pkt_id_d = pkt_id_q + 8'd1;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (send && !credit_i) begin
      credits_d = credits_q - CW'(1);
    end else if (!send && credit_i) begin
      if (credits_q == CW'(BUFFER_SIZE)) begin
        credit_err_d = 1'b1;
      end else begin
        credits_d = credits_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      credits_q    <= CW'(BUFFER_SIZE);
      pkt_id_q     <= '0;
      idx_q        <= '0;
      len_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      fv_q         <= 1'b0;
      ft_q         <= '0;
      fx_q         <= '0;
      fy_q         <= '0;
      fp_q         <= '0;
      pkt_err_q    <= 1'b0;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      credits_q    <= credits_d;
      pkt_id_q     <= pkt_id_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      x_q          <= x_d;
      y_q          <= y_d;
      fv_q         <= fv_d;
      ft_q         <= ft_d;
      fx_q         <= fx_d;
      fy_q         <= fy_d;
      fp_q         <= fp_d;
      pkt_err_q    <= pkt_err_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign pkt_ready_o    = (state_q == StIdle);
  assign pkt_err_o      = pkt_err_q;
  assign flit_valid_o   = fv_q;
  assign flit_type_o    = ft_q;
  assign flit_x_dest_o  = fx_q;
  assign flit_y_dest_o  = fy_q;
  assign flit_payload_o = fp_q;
  assign credit_err_o   = credit_err_q;

endmodule
